yarp_fetch: RTL and testbench

//  Instruction-fetch stage: owns the fetch PC and issues word reads to instruction memory

---
 rtl/yarp_pkg.sv | 18 +
 rtl/yarp_fetch_fifo.sv | 56 +++++
 rtl/yarp_fetch.sv | 115 +++++++++++
 tb/tb_yarp_fetch.sv | 337 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/yarp_pkg.sv
// Shared types for the yarp fetch front end: FSM state encoding
// and the {pc, instr} bundle carried from fetch to decode.
package yarp_pkg;

    localparam logic [31:0] YARP_RESET_PC = 32'h0000_1000;

    typedef enum logic [1:0] {
        ST_REQ  = 2'd0,
        ST_WAIT = 2'd1,
        ST_DROP = 2'd2
    } fetch_state_e;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/yarp_fetch_fifo.sv
// Synchronous FIFO of fetch_entry_t with flush.
// Ports: push/wdata in, pop in, flush in; full, empty, count, head out.
module yarp_fetch_fifo
    import yarp_pkg::*;
#(
    parameter int DEPTH = 2,
    localparam int AW = $clog2(DEPTH),
    localparam int CW = AW + 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          push,
    input  fetch_entry_t  wdata,
    input  logic          pop,
    input  logic          flush,
    output logic          full,
    output logic          empty,
    output logic [CW-1:0] count,
    output fetch_entry_t  head
);

    fetch_entry_t  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;

    assign full  = (count == CW'(DEPTH));
    assign empty = (count == '0);
    assign head  = mem[rd_ptr];

    // Flush wins over any push/pop in the same cycle.
    always_ff @(posedge clk) begin
        if (reset || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            unique case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: ;
            endcase
        end
    end

    // Storage is cleared on reset so the head reads zero while idle.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (push && !flush) begin
            mem[wr_ptr] <= wdata;
        end
    end

endmodule

// File: rtl/yarp_fetch.sv
// Fetch stage: owns fetch PC, issues imem word reads (req/gnt/rvalid),
// buffers {pc,instr} for decode (valid/ready), handles redirects.
// Ports: clk, reset; imem_req_o/addr_o/gnt_i/rvalid_i/rdata_i;
// redirect_i/redirect_pc_i; instr_valid_o/ready_i, instr_o, pc_o.
module yarp_fetch
    import yarp_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = YARP_RESET_PC,
    parameter int          FIFO_DEPTH = 2
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req_o,
    output logic [31:0] imem_addr_o,
    input  logic        imem_gnt_i,
    input  logic        imem_rvalid_i,
    input  logic [31:0] imem_rdata_i,
    input  logic        redirect_i,
    input  logic [31:0] redirect_pc_i,
    output logic        instr_valid_o,
    input  logic        instr_ready_i,
    output logic [31:0] instr_o,
    output logic [31:0] pc_o
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    fetch_state_e  state;
    fetch_state_e  state_next;
    logic [31:0]   fetch_pc;
    logic [31:0]   req_pc;
    logic [31:0]   redirect_pc;
    logic          fire;
    logic          push;
    logic          pop;
    logic          full;
    logic          empty;
    logic [CW-1:0] count;
    fetch_entry_t  push_entry;
    fetch_entry_t  head;

    assign redirect_pc = redirect_pc_i & ~32'h3;
    assign fire        = imem_req_o && imem_gnt_i;
    assign imem_addr_o = fetch_pc;
    assign push_entry  = '{pc: req_pc, instr: imem_rdata_i};

    assign instr_valid_o = !empty && !redirect_i && !reset;
    assign pop           = instr_valid_o && instr_ready_i;
    assign instr_o       = head.instr;
    assign pc_o          = head.pc;

    always_ff @(posedge clk) begin
        if (reset) state <= ST_REQ;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        unique case (state)
            ST_REQ: begin
                if (fire) state_next = redirect_i ? ST_DROP : ST_WAIT;
            end
            ST_WAIT: begin
                if (imem_rvalid_i)   state_next = ST_REQ;
                else if (redirect_i) state_next = ST_DROP;
            end
            ST_DROP: begin
                if (imem_rvalid_i) state_next = ST_REQ;
            end
            default: state_next = ST_REQ;
        endcase
    end

    // A request is only raised with a free slot, so the returning
    // word always fits (a same-cycle pop also frees one).
    always_comb begin
        imem_req_o = 1'b0;
        push       = 1'b0;
        unique case (state)
            ST_REQ:  imem_req_o = (count < CW'(FIFO_DEPTH)) && !reset;
            ST_WAIT: push = imem_rvalid_i && !redirect_i && (!full || pop);
            default: ;
        endcase
    end

    // Redirect loads the new PC in any state; a request withdrawn
    // without grant simply re-issues at the new address.
    always_ff @(posedge clk) begin
        if (reset) begin
            fetch_pc <= RESET_PC;
            req_pc   <= RESET_PC;
        end else if (redirect_i) begin
            fetch_pc <= redirect_pc;
        end else if (fire) begin
            fetch_pc <= fetch_pc + 32'd4;
            req_pc   <= fetch_pc;
        end
    end

    yarp_fetch_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push),
        .wdata (push_entry),
        .pop   (pop),
        .flush (redirect_i),
        .full  (full),
        .empty (empty),
        .count (count),
        .head  (head)
    );

endmodule

// File: tb/tb_yarp_fetch.sv
// Self-checking bench for yarp_fetch: randomized imem/decode
// behaviour against a sequential-PC scoreboard plus directed scenarios.
module tb_yarp_fetch;

    localparam logic [31:0] RST_PC = 32'h0000_1000;

    logic        clk;
    logic        reset;
    logic        imem_req_o;
    logic [31:0] imem_addr_o;
    logic        imem_gnt_i;
    logic        imem_rvalid_i;
    logic [31:0] imem_rdata_i;
    logic        redirect_i;
    logic [31:0] redirect_pc_i;
    logic        instr_valid_o;
    logic        instr_ready_i;
    logic [31:0] instr_o;
    logic [31:0] pc_o;

    int checks   = 0;
    int failures = 0;

    // imem responder state
    int          gnt_pct  = 100;
    int          lat_min  = 1;
    int          lat_max  = 1;
    logic        pend_valid = 1'b0;
    int          pend_cnt = 0;
    logic [31:0] pend_addr = '0;

    // decode / redirect stimulus
    int          ready_pct = 100;
    int          redir_pct = 0;
    logic        redir_req = 1'b0;
    logic [31:0] redir_pc  = '0;

    // reference model and observations
    logic [31:0] exp_pc = RST_PC;
    int          cyc = 0;
    int          first_acc_cyc = -1;
    logic [31:0] gnt_q[$];
    int          gnt_cyc_q[$];
    logic [31:0] acc_q[$];
    logic        last_req;
    logic [31:0] last_addr;
    logic        last_valid;

    yarp_fetch dut (
        .clk           (clk),
        .reset         (reset),
        .imem_req_o    (imem_req_o),
        .imem_addr_o   (imem_addr_o),
        .imem_gnt_i    (imem_gnt_i),
        .imem_rvalid_i (imem_rvalid_i),
        .imem_rdata_i  (imem_rdata_i),
        .redirect_i    (redirect_i),
        .redirect_pc_i (redirect_pc_i),
        .instr_valid_o (instr_valid_o),
        .instr_ready_i (instr_ready_i),
        .instr_o       (instr_o),
        .pc_o          (pc_o)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'hC0DE_5EED;
    endfunction

    function automatic bit roll(input int pct);
        return int'($urandom_range(0, 99)) < pct;
    endfunction

    task automatic clear_obs();
        gnt_q.delete();
        gnt_cyc_q.delete();
        acc_q.delete();
        cyc = 0;
        first_acc_cyc = -1;
    endtask

    // One clock: drive inputs on the falling edge, then observe.
    task automatic step();
        logic gnt;
        @(negedge clk);
        gnt = 1'b0;
        imem_rvalid_i = 1'b0;
        imem_rdata_i  = $urandom;
        if (pend_valid) begin
            if (pend_cnt == 0) begin
                imem_rvalid_i = 1'b1;
                imem_rdata_i  = mem_word(pend_addr);
                pend_valid    = 1'b0;
            end else begin
                pend_cnt--;
            end
        end
        if (!pend_valid && imem_req_o && roll(gnt_pct)) begin
            gnt        = 1'b1;
            pend_valid = 1'b1;
            pend_addr  = imem_addr_o;
            pend_cnt   = int'($urandom_range(lat_min, lat_max)) - 1;
            gnt_q.push_back(imem_addr_o);
            gnt_cyc_q.push_back(cyc);
        end
        imem_gnt_i = gnt;
        if (!redir_req && !reset && redir_pct > 0 && roll(redir_pct)) begin
            redir_req = 1'b1;
            redir_pc  = $urandom;
        end
        redirect_i    = redir_req;
        redirect_pc_i = redir_req ? redir_pc : $urandom;
        redir_req     = 1'b0;
        instr_ready_i = roll(ready_pct);
        if (reset)           exp_pc = RST_PC;
        else if (redirect_i) exp_pc = redirect_pc_i & ~32'h3;
        #1;
        last_req   = imem_req_o;
        last_addr  = imem_addr_o;
        last_valid = instr_valid_o;
        if (imem_req_o) begin
            checks++;
            if (imem_addr_o[1:0] !== 2'b00) begin
                failures++;
                $display("FAIL addr_align: got %h", imem_addr_o);
            end
        end
        if (redirect_i) begin
            checks++;
            if (instr_valid_o !== 1'b0) begin
                failures++;
                $display("FAIL valid_on_redirect: got %b want 0", instr_valid_o);
            end
        end
        if (instr_valid_o === 1'b1 && instr_ready_i) begin
            checks++;
            if (pc_o !== exp_pc || instr_o !== mem_word(exp_pc)) begin
                failures++;
                $display("FAIL scoreboard: got pc=%h instr=%h want pc=%h instr=%h",
                         pc_o, instr_o, exp_pc, mem_word(exp_pc));
            end
            acc_q.push_back(pc_o);
            if (first_acc_cyc < 0) first_acc_cyc = cyc;
            exp_pc = exp_pc + 32'd4;
        end
        cyc++;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic do_reset();
        reset = 1'b1;
        pend_valid = 1'b0;
        run(2);
        reset  = 1'b0;
        exp_pc = RST_PC;
        clear_obs();
    endtask

    task automatic check_q(input string name, input logic [31:0] q[$],
                           input int idx, input logic [31:0] want);
        checks++;
        if (idx >= q.size()) begin
            failures++;
            $display("FAIL %s: only %0d entries, want [%0d]=%h", name, q.size(), idx, want);
        end else if (q[idx] !== want) begin
            failures++;
            $display("FAIL %s[%0d]: got %h want %h", name, idx, q[idx], want);
        end
    endtask

    task automatic test_reset();
        gnt_pct = 0;
        ready_pct = 100;
        reset = 1'b1;
        run(2);
        checks++;
        if (last_req !== 1'b0 || last_valid !== 1'b0) begin
            failures++;
            $display("FAIL reset_ctrl: req=%b valid=%b want 0 0", last_req, last_valid);
        end
        checks++;
        if (imem_addr_o !== RST_PC || pc_o !== 32'h0 || instr_o !== 32'h0) begin
            failures++;
            $display("FAIL reset_data: addr=%h pc=%h instr=%h want %h 0 0",
                     imem_addr_o, pc_o, instr_o, RST_PC);
        end
        reset = 1'b0;
        exp_pc = RST_PC;
        clear_obs();
        step();
        checks++;
        if (last_req !== 1'b1 || last_addr !== RST_PC) begin
            failures++;
            $display("FAIL first_req: req=%b addr=%h want 1 %h", last_req, last_addr, RST_PC);
        end
    endtask

    task automatic test_stream();
        gnt_pct = 100; lat_min = 1; lat_max = 1; ready_pct = 100;
        do_reset();
        run(12);
        for (int i = 0; i < 6; i++) check_q("stream_gnt", gnt_q, i, RST_PC + 32'(4 * i));
        for (int i = 0; i < 5; i++) check_q("stream_acc", acc_q, i, RST_PC + 32'(4 * i));
        checks++;
        if (first_acc_cyc !== 2) begin
            failures++;
            $display("FAIL first_valid_cycle: got %0d want 2", first_acc_cyc);
        end
    endtask

    task automatic test_backpressure();
        gnt_pct = 100; lat_min = 1; lat_max = 1; ready_pct = 0;
        do_reset();
        run(10);
        checks++;
        if (gnt_q.size() != 2 || last_req !== 1'b0) begin
            failures++;
            $display("FAIL bp_stall: grants=%0d req=%b want 2 0", gnt_q.size(), last_req);
        end
        checks++;
        if (last_valid !== 1'b1 || pc_o !== RST_PC) begin
            failures++;
            $display("FAIL bp_head: valid=%b pc=%h want 1 %h", last_valid, pc_o, RST_PC);
        end
        ready_pct = 100;
        run(10);
        check_q("bp_drain", acc_q, 0, RST_PC);
        check_q("bp_drain", acc_q, 1, RST_PC + 32'd4);
        check_q("bp_resume", gnt_q, 2, RST_PC + 32'd8);
    endtask

    task automatic test_redirect_wait();
        gnt_pct = 100; lat_min = 3; lat_max = 3; ready_pct = 100;
        do_reset();
        step();
        redir_req = 1'b1;
        redir_pc  = 32'h0000_2002;
        step();
        clear_obs();
        run(20);
        check_q("rw_gnt", gnt_q, 0, 32'h0000_2000);
        check_q("rw_acc", acc_q, 0, 32'h0000_2000);
    endtask

    task automatic test_redirect_rvalid();
        gnt_pct = 100; lat_min = 1; lat_max = 1; ready_pct = 0;
        do_reset();
        run(3);
        redir_req = 1'b1;
        redir_pc  = 32'h0000_3000;
        step();
        checks++;
        if (last_valid !== 1'b0) begin
            failures++;
            $display("FAIL rr_valid: got %b want 0", last_valid);
        end
        ready_pct = 100;
        clear_obs();
        step();
        checks++;
        if (last_req !== 1'b1 || last_addr !== 32'h0000_3000 || last_valid !== 1'b0) begin
            failures++;
            $display("FAIL rr_next: req=%b addr=%h valid=%b want 1 00003000 0",
                     last_req, last_addr, last_valid);
        end
        run(10);
        check_q("rr_acc", acc_q, 0, 32'h0000_3000);
    endtask

    task automatic test_wrap();
        gnt_pct = 100; lat_min = 1; lat_max = 1; ready_pct = 100;
        do_reset();
        redir_req = 1'b1;
        redir_pc  = 32'hFFFF_FFFC;
        step();
        clear_obs();
        run(12);
        check_q("wrap_gnt", gnt_q, 0, 32'hFFFF_FFFC);
        check_q("wrap_gnt", gnt_q, 1, 32'h0000_0000);
        check_q("wrap_acc", acc_q, 1, 32'h0000_0000);
    endtask

    task automatic test_reset_mid();
        gnt_pct = 100; lat_min = 3; lat_max = 3; ready_pct = 100;
        do_reset();
        run(5);
        reset = 1'b1;
        step();
        reset  = 1'b0;
        exp_pc = RST_PC;
        clear_obs();
        run(15);
        check_q("rm_gnt", gnt_q, 0, RST_PC);
        check_q("rm_acc", acc_q, 0, RST_PC);
        check_q("rm_acc", acc_q, 1, RST_PC + 32'd4);
    endtask

    task automatic test_random();
        gnt_pct = 60; lat_min = 1; lat_max = 3; ready_pct = 60; redir_pct = 4;
        do_reset();
        run(800);
        redir_pct = 0;
        checks++;
        if (acc_q.size() < 40) begin
            failures++;
            $display("FAIL rand_progress: accepted %0d want >= 40", acc_q.size());
        end
    endtask

    initial begin
        reset = 1'b1;
        imem_gnt_i = 1'b0;
        imem_rvalid_i = 1'b0;
        imem_rdata_i = '0;
        redirect_i = 1'b0;
        redirect_pc_i = '0;
        instr_ready_i = 1'b0;
        test_reset();
        test_stream();
        test_backpressure();
        test_redirect_wait();
        test_redirect_rvalid();
        test_wrap();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
